// File: rtl/irq_pkg.sv
// Shared constants for the timer/abnormal interrupt request controller:
// register map, TCON bit positions, cause codes and FSM state encoding.
package irq_pkg;

  localparam logic [1:0] ADDR_TH   = 2'd0;
  localparam logic [1:0] ADDR_TL   = 2'd1;
  localparam logic [1:0] ADDR_TCON = 2'd2;

  localparam int TCON_EN  = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_EXP = 2;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_TIMER = 2'd1,
    CAUSE_UNDEF = 2'd2,
    CAUSE_OVF   = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

endpackage

// File: rtl/irq_timer.sv
// Reload timer: TH reload, TL up-counter, TCON {expired, irq_en, run_en}.
// Ports: clk, reset_jump_inte_abn, register write/read bus, o_tmr_evt.
module irq_timer
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_jump_inte_abn,
  input  logic        i_wr_en,
  input  logic [1:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic [1:0]  i_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_tmr_evt
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;

  logic w_wr_th;
  logic w_wr_tl;
  logic w_wr_tcon;
  logic w_wrap;

  assign w_wr_th   = i_wr_en && (i_wr_addr == ADDR_TH);
  assign w_wr_tl   = i_wr_en && (i_wr_addr == ADDR_TL);
  assign w_wr_tcon = i_wr_en && (i_wr_addr == ADDR_TCON);

  // A software TL write suppresses the reload, so no expiry either.
  assign w_wrap = r_tcon[TCON_EN]
                && (r_tl == TL_MAX)
                && !w_wr_tl;

  assign o_tmr_evt = w_wrap && r_tcon[TCON_IE];

  always_ff @(posedge clk or posedge reset_jump_inte_abn) begin
    if (reset_jump_inte_abn) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (w_wr_th)
        r_th <= i_wr_data;
      if (w_wr_tl)
        r_tl <= i_wr_data;
      else if (r_tcon[TCON_EN])
        r_tl <= (r_tl == TL_MAX) ? r_th : r_tl + 32'd1;
      if (w_wr_tcon) begin
        r_tcon[TCON_EN] <= i_wr_data[TCON_EN];
        r_tcon[TCON_IE] <= i_wr_data[TCON_IE];
      end
      // Hardware expiry beats a software clear in the same cycle.
      if (w_wrap)
        r_tcon[TCON_EXP] <= 1'b1;
      else if (w_wr_tcon && !i_wr_data[TCON_EXP])
        r_tcon[TCON_EXP] <= 1'b0;
    end
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_addr)
      ADDR_TH:   o_rd_data = r_th;
      ADDR_TL:   o_rd_data = r_tl;
      ADDR_TCON: o_rd_data = {29'd0, r_tcon};
      default:   o_rd_data = '0;
    endcase
  end

endmodule

// File: rtl/irq_request_ctrl.sv
// Interrupt request controller: pending latches, abnormal-over-timer
// priority and IDLE/REQ/HANDLER request FSM around the reload timer.
module irq_request_ctrl
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_jump_inte_abn,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        undef_inst_i,
  input  logic        ovf_i,
  input  logic        ack_i,
  input  logic        eret_i,
  output logic        req_interrupt_timer,
  output logic        req_abnormal,
  output logic [1:0]  cause,
  output logic        in_handler
);

  state_e r_state;
  cause_e r_cause;
  logic   r_req_t;
  logic   r_req_a;
  logic   r_inh;
  logic   r_pend_t;
  logic   r_pend_u;
  logic   r_pend_o;

  logic w_tmr_evt;
  logic w_abn_any;
  logic w_undef_any;
  logic w_tmr_any;
  logic w_ack;
  logic w_clr_a;
  logic w_clr_t;

  irq_timer u_timer (
    .clk                 (clk),
    .reset_jump_inte_abn (reset_jump_inte_abn),
    .i_wr_en             (wr_en),
    .i_wr_addr           (wr_addr),
    .i_wr_data           (wr_data),
    .i_rd_addr           (rd_addr),
    .o_rd_data           (rd_data),
    .o_tmr_evt           (w_tmr_evt)
  );

  // Same-cycle events count as pending so IDLE reacts on the next edge.
  assign w_abn_any   = r_pend_u | r_pend_o
                     | undef_inst_i | ovf_i;
  assign w_undef_any = r_pend_u | undef_inst_i;
  assign w_tmr_any   = r_pend_t | w_tmr_evt;

  assign w_ack   = (r_state == ST_REQ) && ack_i;
  assign w_clr_a = w_ack && r_req_a;
  assign w_clr_t = w_ack && r_req_t;

  always_ff @(posedge clk or posedge reset_jump_inte_abn) begin
    if (reset_jump_inte_abn) begin
      r_state  <= ST_IDLE;
      r_cause  <= CAUSE_NONE;
      r_req_t  <= 1'b0;
      r_req_a  <= 1'b0;
      r_inh    <= 1'b0;
      r_pend_t <= 1'b0;
      r_pend_u <= 1'b0;
      r_pend_o <= 1'b0;
    end else begin
      // New events win over the clear of the served source.
      r_pend_t <= (r_pend_t & ~w_clr_t) | w_tmr_evt;
      r_pend_u <= (r_pend_u & ~w_clr_a) | undef_inst_i;
      r_pend_o <= (r_pend_o & ~w_clr_a) | ovf_i;
      case (r_state)
        ST_IDLE: begin
          if (w_abn_any) begin
            r_state <= ST_REQ;
            r_req_a <= 1'b1;
            r_cause <= w_undef_any ? CAUSE_UNDEF
                                   : CAUSE_OVF;
          end else if (w_tmr_any) begin
            r_state <= ST_REQ;
            r_req_t <= 1'b1;
            r_cause <= CAUSE_TIMER;
          end
        end
        ST_REQ: begin
          if (ack_i) begin
            r_state <= ST_HANDLER;
            r_req_a <= 1'b0;
            r_req_t <= 1'b0;
            r_inh   <= 1'b1;
          end
        end
        ST_HANDLER: begin
          if (eret_i) begin
            r_state <= ST_IDLE;
            r_inh   <= 1'b0;
            r_cause <= CAUSE_NONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_interrupt_timer = r_req_t;
  assign req_abnormal        = r_req_a;
  assign cause               = r_cause;
  assign in_handler          = r_inh;

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Self-checking bench for irq_request_ctrl: vector table, directed
// corner sequences and random stimulus against a behavioural model.
module tb_irq_request_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        undef_inst_i;
  logic        ovf_i;
  logic        ack_i;
  logic        eret_i;
  logic        req_interrupt_timer;
  logic        req_abnormal;
  logic [1:0]  cause;
  logic        in_handler;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  irq_request_ctrl dut (
    .clk                 (clk),
    .reset_jump_inte_abn (rst),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .undef_inst_i        (undef_inst_i),
    .ovf_i               (ovf_i),
    .ack_i               (ack_i),
    .eret_i              (eret_i),
    .req_interrupt_timer (req_interrupt_timer),
    .req_abnormal        (req_abnormal),
    .cause               (cause),
    .in_handler          (in_handler)
  );

  // Behavioural model: mode 0 idle, 1 requesting, 2 in handler.
  logic [31:0] m_th, m_tl;
  logic        m_en, m_ie, m_st;
  logic        m_pt, m_pu, m_po;
  int          m_mode;
  logic        m_rt, m_ra, m_ih;
  logic [1:0]  m_c;

  task automatic m_reset();
    m_th = 0; m_tl = 0;
    m_en = 0; m_ie = 0; m_st = 0;
    m_pt = 0; m_pu = 0; m_po = 0;
    m_mode = 0;
    m_rt = 0; m_ra = 0; m_ih = 0; m_c = 0;
  endtask

  function automatic logic [31:0] m_rd(logic [1:0] a);
    case (a)
      2'd0: return m_th;
      2'd1: return m_tl;
      2'd2: return {29'd0, m_st, m_ie, m_en};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step();
    logic wth, wtl, wtc, wrap, tevt, served_a, served_t;
    logic [31:0] ntl;
    wth = wr_en && wr_addr == 2'd0;
    wtl = wr_en && wr_addr == 2'd1;
    wtc = wr_en && wr_addr == 2'd2;
    wrap = m_en && m_tl == 32'hFFFFFFFF && !wtl;
    tevt = wrap && m_ie;
    served_a = 0;
    served_t = 0;
    if (wtl) ntl = wr_data;
    else if (!m_en) ntl = m_tl;
    else if (m_tl == 32'hFFFFFFFF) ntl = m_th;
    else ntl = m_tl + 1;
    if (m_mode == 0) begin
      if (m_pu || m_po || undef_inst_i || ovf_i) begin
        m_mode = 1; m_ra = 1;
        m_c = (m_pu || undef_inst_i) ? 2'd2 : 2'd3;
      end else if (m_pt || tevt) begin
        m_mode = 1; m_rt = 1; m_c = 2'd1;
      end
    end else if (m_mode == 1) begin
      if (ack_i) begin
        served_a = m_ra; served_t = m_rt;
        m_mode = 2; m_ra = 0; m_rt = 0; m_ih = 1;
      end
    end else if (eret_i) begin
      m_mode = 0; m_ih = 0; m_c = 0;
    end
    if (served_t) m_pt = 0;
    if (served_a) begin m_pu = 0; m_po = 0; end
    if (tevt) m_pt = 1;
    if (undef_inst_i) m_pu = 1;
    if (ovf_i) m_po = 1;
    m_tl = ntl;
    if (wth) m_th = wr_data;
    if (wtc) begin m_en = wr_data[0]; m_ie = wr_data[1]; end
    if (wrap) m_st = 1;
    else if (wtc && !wr_data[2]) m_st = 0;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk4(string nm, logic rt, logic ra, logic [1:0] c, logic ih);
    chk({nm, ".req_tmr"}, {31'd0, req_interrupt_timer}, {31'd0, rt});
    chk({nm, ".req_abn"}, {31'd0, req_abnormal}, {31'd0, ra});
    chk({nm, ".cause"}, {30'd0, cause}, {30'd0, c});
    chk({nm, ".in_hdl"}, {31'd0, in_handler}, {31'd0, ih});
  endtask

  task automatic tick();
    if (rst) m_reset();
    else m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(logic we, logic [1:0] wa, logic [31:0] wd,
                    logic [1:0] ra, logic un, logic ov,
                    logic ak, logic er);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    undef_inst_i = un; ovf_i = ov; ack_i = ak; eret_i = er;
    tick();
    wr_en = 0; undef_inst_i = 0; ovf_i = 0; ack_i = 0; eret_i = 0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic        un, ov, ak, er;
    logic        xrt, xra;
    logic [1:0]  xc;
    logic        xih;
    logic [31:0] xrd;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 32'hFFFFFFFD, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFD};
    tbl[1]  = '{1'b1, 2'd1, 32'hFFFFFFFD, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFD};
    tbl[2]  = '{1'b1, 2'd2, 32'd3,        2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFD};
    tbl[3]  = '{1'b0, 2'd0, 32'd0,        2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFE};
    tbl[4]  = '{1'b0, 2'd0, 32'd0,        2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFF};
    tbl[5]  = '{1'b0, 2'd0, 32'd0,        2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'hFFFFFFFD};
    tbl[6]  = '{1'b0, 2'd0, 32'd0,        2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'd7};
    tbl[7]  = '{1'b1, 2'd2, 32'd0,        2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 32'd0};
    tbl[8]  = '{1'b0, 2'd0, 32'd0,        2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFF};
    tbl[9]  = '{1'b0, 2'd0, 32'd0,        2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFD};
    tbl[10] = '{1'b0, 2'd0, 32'd0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFD};
    tbl[11] = '{1'b0, 2'd0, 32'd0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFD};
    tbl[12] = '{1'b0, 2'd0, 32'd0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFD};
    tbl[13] = '{1'b0, 2'd0, 32'd0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFD};
    tbl[14] = '{1'b0, 2'd0, 32'd0,        2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 32'hFFFFFFFD};
    tbl[15] = '{1'b0, 2'd0, 32'd0,        2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFD};
    tbl[16] = '{1'b0, 2'd0, 32'd0,        2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0};

    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 2'd2;
    undef_inst_i = 0; ovf_i = 0; ack_i = 0; eret_i = 0;
    tick();
    tick();
    chk4("reset", 0, 0, 0, 0);
    chk("reset.tcon", rd_data, 32'd0);
    rst = 0;

    for (int i = 0; i < 17; i++) begin
      op(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra,
         tbl[i].un, tbl[i].ov, tbl[i].ak, tbl[i].er);
      chk4($sformatf("row%0d", i), tbl[i].xrt, tbl[i].xra,
           tbl[i].xc, tbl[i].xih);
      chk($sformatf("row%0d.rd", i), rd_data, tbl[i].xrd);
    end

    // Timer wrap and overflow in the same cycle.
    op(1, 2'd0, 32'd0, 2'd1, 0, 0, 0, 0);
    op(1, 2'd1, 32'hFFFFFFFE, 2'd1, 0, 0, 0, 0);
    op(1, 2'd2, 32'd3, 2'd1, 0, 0, 0, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 0);
    chk("both.tl", rd_data, 32'hFFFFFFFF);
    op(0, 2'd0, 32'd0, 2'd1, 0, 1, 0, 0);
    chk4("both.abn", 0, 1, 3, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 1, 0);
    chk4("both.ack", 0, 0, 3, 1);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 1);
    chk4("both.eret", 0, 0, 0, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 0);
    chk4("both.tmr", 1, 0, 1, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 1, 0);
    chk4("both.ack2", 0, 0, 1, 1);

    // Overflow during handler waits for eret.
    op(0, 2'd0, 32'd0, 2'd1, 0, 1, 0, 0);
    chk4("hdl.ovf", 0, 0, 1, 1);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 0);
    chk4("hdl.wait", 0, 0, 1, 1);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 1);
    chk4("hdl.eret", 0, 0, 0, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 0);
    chk4("hdl.rereq", 0, 1, 3, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 1, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 1);
    chk4("hdl.done", 0, 0, 0, 0);

    // Stray ack/eret ignored; event on the ack cycle kept.
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 1, 0);
    chk4("ign.ack", 0, 0, 0, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 1);
    chk4("ign.eret", 0, 0, 0, 0);
    op(0, 2'd0, 32'd0, 2'd1, 1, 0, 0, 0);
    chk4("ign.undef", 0, 1, 2, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 1);
    chk4("ign.eret_req", 0, 1, 2, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 1, 1, 0);
    chk4("ackev.ack", 0, 0, 2, 1);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 1);
    chk4("ackev.eret", 0, 0, 0, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 0);
    chk4("ackev.rereq", 0, 1, 3, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 1, 0);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 1);

    // IRQ disabled through wrap; TL write beats increment.
    op(1, 2'd2, 32'd1, 2'd2, 0, 0, 0, 0);
    chk("dis.tcon", rd_data, 32'd1);
    op(1, 2'd1, 32'hFFFFFFFE, 2'd1, 0, 0, 0, 0);
    chk("dis.tlwr", rd_data, 32'hFFFFFFFE);
    op(0, 2'd0, 32'd0, 2'd1, 0, 0, 0, 0);
    op(0, 2'd0, 32'd0, 2'd2, 0, 0, 0, 0);
    chk("dis.tcon5", rd_data, 32'd5);
    chk4("dis.noreq", 0, 0, 0, 0);
    op(0, 2'd0, 32'd0, 2'd2, 0, 0, 0, 0);
    chk4("dis.noreq2", 0, 0, 0, 0);
    op(1, 2'd2, 32'd1, 2'd2, 0, 0, 0, 0);
    chk("dis.clr", rd_data, 32'd1);
    op(1, 2'd1, 32'hFFFFFFFF, 2'd2, 0, 0, 0, 0);
    op(1, 2'd2, 32'd1, 2'd2, 0, 0, 0, 0);
    chk("dis.hwwin", rd_data, 32'd5);

    // Asynchronous reset in the middle of a request.
    op(1, 2'd2, 32'd3, 2'd2, 0, 0, 0, 0);
    op(0, 2'd0, 32'd0, 2'd2, 1, 0, 0, 0);
    chk4("arst.pre", 0, 1, 2, 0);
    #2;
    rst = 1;
    m_reset();
    #1;
    chk4("arst.now", 0, 0, 0, 0);
    chk("arst.tcon", rd_data, 32'd0);
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      op(0, 2'd0, 32'd0, 2'd2, 0, 0, 0, 0);
      chk4($sformatf("arst.post%0d", i), 0, 0, 0, 0);
    end
    op(1, 2'd1, 32'd5, 2'd1, 0, 0, 0, 0);
    chk("arst.resume", rd_data, 32'd5);

    // Random traffic against the model.
    op(1, 2'd2, 32'd3, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      wr_en = ($urandom_range(0, 5) == 0);
      wr_addr = 2'($urandom_range(0, 2));
      case (wr_addr)
        2'd0: wr_data = 32'hFFFFFFE0 | 32'($urandom_range(0, 31));
        2'd1: wr_data = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
        default: wr_data = 32'($urandom_range(0, 7));
      endcase
      rd_addr = 2'($urandom_range(0, 3));
      undef_inst_i = ($urandom_range(0, 11) == 0);
      ovf_i = ($urandom_range(0, 11) == 0);
      ack_i = ($urandom_range(0, 2) == 0);
      eret_i = ($urandom_range(0, 3) == 0);
      tick();
      chk4($sformatf("rnd%0d", i), m_rt, m_ra, m_c, m_ih);
      chk($sformatf("rnd%0d.rd", i), rd_data, m_rd(rd_addr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_request_ctrl.md
IRQ_REQUEST_CTRL -- requirements
Module: irq_request_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset_jump_inte_abn  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: wr_en  input  1  register write strobe.
REQ-004 SHALL have port: wr_addr  input  2  write select (0=TH reload, 1=TL count, 2=TCON).
REQ-005 SHALL have port: wr_data  input  32  write data.
REQ-006 SHALL have port: rd_addr  input  2  read select, same map; 3 reads zero.
REQ-007 SHALL have port: rd_data  output  32  combinational read of selected register.
REQ-008 SHALL have port: undef_inst_i  input  1  decoder flags illegal instruction (abnormal source).
REQ-009 SHALL have port: ovf_i  input  1  ALU signed overflow (abnormal source).
REQ-010 SHALL have port: ack_i  input  1  one-cycle pulse, PC has taken the vector.
REQ-011 SHALL have port: eret_i  input  1  one-cycle pulse, handler return executed.
REQ-012 SHALL have port: req_interrupt_timer  output  1  registered timer request level.
REQ-013 SHALL have port: req_abnormal  output  1  registered abnormal request level.
REQ-014 SHALL have port: cause  output  2  registered cause (0 none, 1 timer, 2 undef, 3 overflow).
REQ-015 SHALL have port: in_handler  output  1  registered, high while a handler is active.

Function
REQ-016 TCON SHALL hold bit0 timer enable, bit1 IRQ enable, bit2 expired status; bits 31:3 read zero.
REQ-017 When TCON[0]=1, TL SHALL increment by 1 each clk; TL=32'hFFFFFFFF SHALL reload TH next cycle and set TCON[2].
REQ-018 A TL write SHALL take priority over increment/reload in the same cycle.
REQ-019 A TCON write SHALL load bits 1:0 and clear bit2 only when wr_data[2]=0; hardware set of bit2 in the same cycle SHALL win.
REQ-020 Timer pending SHALL set on the reload cycle when TCON[1]=1; abnormal pending SHALL latch on undef_inst_i or ovf_i, undef having priority for cause.
REQ-021 FSM SHALL have states IDLE, REQ, HANDLER.
REQ-022 IDLE: any pending SHALL move to REQ next cycle, raising req_abnormal if abnormal pending else req_interrupt_timer, and set cause; exactly one request high.
REQ-023 Abnormal SHALL outrank timer when both pend in the same cycle; unserved timer stays pending.
REQ-024 REQ: request and cause SHALL hold until ack_i; on ack_i, next cycle request low, served pending bit cleared, in_handler=1, state HANDLER.
REQ-025 HANDLER: new events SHALL latch as pending but not raise requests; eret_i SHALL return to IDLE with in_handler=0, cause=0.
REQ-026 Remaining pending in IDLE after eret_i SHALL re-request one cycle later (back-to-back service).
REQ-027 ack_i outside REQ and eret_i outside HANDLER SHALL be ignored.
REQ-028 An event arriving on the ack_i cycle SHALL be latched, not lost.

Reset
REQ-029 Asserting reset_jump_inte_abn SHALL immediately clear TH, TL, TCON, pending bits, all outputs and set IDLE, including mid-REQ or mid-HANDLER.
REQ-030 Operation SHALL resume on the first clk edge after deassertion.

Structure
REQ-031 Register addresses, TCON bit positions, cause codes and FSM state encodings SHALL live in shared package irq_pkg.
REQ-032 Counter/reload/status logic SHALL be sub-module irq_timer; FSM and priority in irq_request_ctrl.

Verification
REQ-033 TH=TL=0xFFFFFFFD, TCON=3 -> TL FD,FE,FF, reload to FD, req_interrupt_timer=1, cause=1 on next cycle.
REQ-034 undef_inst_i pulse in IDLE -> req_abnormal=1, cause=2 next cycle; held 5 cycles until ack_i; then in_handler=1, req_abnormal=0.
REQ-035 Timer wrap and ovf_i same cycle -> req_abnormal first, cause=3; after ack_i+eret_i, req_interrupt_timer=1, cause=1.
REQ-036 ovf_i while HANDLER -> no request until eret_i, then req_abnormal=1 one cycle later.
REQ-037 reset_jump_inte_abn asserted mid-REQ between edges -> outputs 0 immediately, TCON reads 0, no request after release.
REQ-038 TCON=1 (IRQ disabled) through wrap -> TCON reads 5, no request; write TCON=1 -> reads 1.
